lsu_misalign_splitter: RTL and testbench

//  MEM-stage load/store front end sitting directly upstream of DataMemory.

---
 rtl/lsu_misalign_splitter_pkg.sv | 24 ++
 rtl/lsu_misalign_splitter_if.sv | 27 ++
 rtl/lsu_misalign_splitter_load_extend.sv | 20 ++
 rtl/lsu_misalign_splitter.sv | 143 ++++++++++++++
 tb/tb_lsu_misalign_splitter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_misalign_splitter_pkg.sv
// Shared types and constants for the MEM-stage load/store splitter.
// Funct3 codes follow the RISC-V load/store encoding.
package lsu_misalign_splitter_pkg;

  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_HALF = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;

  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_SPLIT,
    LSU_DONE
  } lsu_state_t;

  // Index of the final byte beat: 1 for halfwords, 3 for words.
  function automatic logic [1:0] last_index(input logic [2:0] f3);
    return (f3[1:0] == 2'b10) ? 2'd3 : 2'd1;
  endfunction

endpackage

// File: rtl/lsu_misalign_splitter_if.sv
// Pipeline request/response and DataMemory signals of the load/store splitter.
interface lsu_misalign_splitter_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        fault;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output stall, fault, resp_valid, resp_rdata, mem_we, mem_funct3, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  stall, fault, resp_valid, resp_rdata, mem_we, mem_funct3, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_misalign_splitter_load_extend.sv
// Sign/zero-extends a little-endian 4-byte load buffer according to the load funct3.
module lsu_load_extend
  import lsu_misalign_splitter_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  always_comb begin
    case (funct3)
      F3_BYTE: result = {{24{raw[7]}}, raw[7:0]};
      F3_BU:   result = {24'd0, raw[7:0]};
      F3_HALF: result = {{16{raw[15]}}, raw[15:0]};
      F3_HU:   result = {16'd0, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/lsu_misalign_splitter.sv
// MEM-stage front end: aligned accesses pass through combinationally, misaligned
// ones are replayed as single-byte beats while the pipeline stalls.
module lsu_misalign_splitter
  import lsu_misalign_splitter_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  lsu_misalign_splitter_if.slave bus
);

  lsu_state_t  state_reg;
  logic [1:0]  cnt_reg;
  logic [1:0]  last_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  funct3_reg;
  logic        we_reg;

  logic        misaligned;
  logic        fault_cond;
  logic        accept;
  logic [7:0]  wr_byte;
  logic [31:0] assembled;
  logic [31:0] extended;

  // Memory picks the halfword by addr[1] alone, so offset 1 is misaligned too.
  always_comb begin
    misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    fault_cond = ((bus.req_addr & MMIO_BASE) != 32'd0) || !ALLOW_MISALIGNED;
    accept     = (state_reg == LSU_IDLE) && bus.req_valid && misaligned && !fault_cond;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= LSU_IDLE;
      cnt_reg    <= 2'd0;
      last_reg   <= 2'd0;
      addr_reg   <= 32'd0;
      wdata_reg  <= 32'd0;
      funct3_reg <= 3'd0;
      we_reg     <= 1'b0;
    end else begin
      case (state_reg)
        LSU_IDLE: begin
          if (accept) begin
            addr_reg   <= bus.req_addr;
            wdata_reg  <= bus.req_wdata;
            funct3_reg <= bus.req_funct3;
            we_reg     <= bus.req_we;
            last_reg   <= last_index(bus.req_funct3);
            cnt_reg    <= 2'd0;
            state_reg  <= LSU_SPLIT;
          end
        end
        LSU_SPLIT: begin
          if (cnt_reg == last_reg) state_reg <= LSU_DONE;
          else                     cnt_reg   <= cnt_reg + 2'd1;
        end
        default: state_reg <= LSU_IDLE;
      endcase
    end
  end

  // One capture register per result byte; beat k fills byte k (little-endian).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          lane_reg <= 8'd0;
        else if (accept)
          lane_reg <= 8'd0;
        else if (state_reg == LSU_SPLIT && !we_reg && cnt_reg == 2'(gi))
          lane_reg <= bus.mem_rdata[7:0];
      end
      assign assembled[8*gi +: 8] = lane_reg;
    end
  endgenerate

  always_comb begin
    case (cnt_reg)
      2'd0:    wr_byte = wdata_reg[7:0];
      2'd1:    wr_byte = wdata_reg[15:8];
      2'd2:    wr_byte = wdata_reg[23:16];
      default: wr_byte = wdata_reg[31:24];
    endcase
  end

  lsu_load_extend u_extend (
    .raw    (assembled),
    .funct3 (funct3_reg),
    .result (extended)
  );

  // Outputs are forced low while reset is held so no write can leak out mid-split.
  always_comb begin
    bus.stall      = 1'b0;
    bus.fault      = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 32'd0;
    bus.mem_we     = 1'b0;
    bus.mem_funct3 = 3'd0;
    bus.mem_addr   = 32'd0;
    bus.mem_wdata  = 32'd0;
    if (rst_n) begin
      case (state_reg)
        LSU_IDLE: begin
          bus.mem_addr   = bus.req_addr;
          bus.mem_funct3 = bus.req_funct3;
          bus.mem_wdata  = bus.req_wdata;
          bus.resp_rdata = bus.mem_rdata;
          if (!misaligned) begin
            bus.mem_we     = bus.req_valid & bus.req_we;
            bus.resp_valid = bus.req_valid & ~bus.req_we;
          end else if (fault_cond) begin
            bus.fault = bus.req_valid;
          end else begin
            bus.stall = bus.req_valid;
          end
        end
        LSU_SPLIT: begin
          bus.stall      = 1'b1;
          bus.mem_addr   = addr_reg + {30'd0, cnt_reg};
          bus.mem_funct3 = we_reg ? F3_BYTE : F3_BU;
          bus.mem_wdata  = {24'd0, wr_byte};
          bus.mem_we     = we_reg;
        end
        LSU_DONE: begin
          bus.mem_addr   = addr_reg;
          bus.mem_funct3 = funct3_reg;
          bus.resp_valid = ~we_reg;
          bus.resp_rdata = we_reg ? 32'd0 : extended;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_misalign_splitter.sv
// Directed bench for lsu_misalign_splitter with a byte-addressed DataMemory model.
module tb_lsu_misalign_splitter;
  import lsu_misalign_splitter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [7:0]  tmem [1024];
  logic        poke_en = 1'b0;
  logic [9:0]  poke_addr = 10'd0;
  logic [31:0] poke_data = 32'd0;
  logic [9:0]  ra;
  logic [7:0]  rb0, rb1, rb2, rb3, rbyte;
  logic [15:0] rhalf;

  lsu_misalign_splitter_if m ();
  lsu_misalign_splitter_if m0 ();

  lsu_misalign_splitter #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m.slave)
  );

  lsu_misalign_splitter #(.ALLOW_MISALIGNED(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m0.slave)
  );

  always #5 clk = ~clk;

  // DataMemory read: combinational, extended by funct3 like the real memory.
  always_comb begin
    ra    = m.mem_addr[9:0];
    rb0   = tmem[{ra[9:2], 2'd0}];
    rb1   = tmem[{ra[9:2], 2'd1}];
    rb2   = tmem[{ra[9:2], 2'd2}];
    rb3   = tmem[{ra[9:2], 2'd3}];
    rhalf = ra[1] ? {rb3, rb2} : {rb1, rb0};
    case (ra[1:0])
      2'd0:    rbyte = rb0;
      2'd1:    rbyte = rb1;
      2'd2:    rbyte = rb2;
      default: rbyte = rb3;
    endcase
    case (m.mem_funct3)
      F3_BYTE: m.mem_rdata = {{24{rbyte[7]}}, rbyte};
      F3_BU:   m.mem_rdata = {24'd0, rbyte};
      F3_HALF: m.mem_rdata = {{16{rhalf[15]}}, rhalf};
      F3_HU:   m.mem_rdata = {16'd0, rhalf};
      default: m.mem_rdata = {rb3, rb2, rb1, rb0};
    endcase
  end

  always @(posedge clk) begin
    if (poke_en) begin
      for (int i = 0; i < 4; i++) tmem[poke_addr + 10'(i)] <= poke_data[8*i +: 8];
    end else if (m.mem_we) begin
      case (m.mem_funct3)
        F3_BYTE: tmem[m.mem_addr[9:0]] <= m.mem_wdata[7:0];
        F3_HALF: begin
          tmem[{m.mem_addr[9:1], 1'b0}] <= m.mem_wdata[7:0];
          tmem[{m.mem_addr[9:1], 1'b1}] <= m.mem_wdata[15:8];
        end
        default: for (int i = 0; i < 4; i++) tmem[{m.mem_addr[9:2], 2'(i)}] <= m.mem_wdata[8*i +: 8];
      endcase
    end
  end

  task automatic poke4(input logic [9:0] a, input logic [31:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    m.req_valid = v; m.req_we = we; m.req_funct3 = f3; m.req_addr = a; m.req_wdata = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, F3_BYTE, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    m0.req_valid = 1'b0; m0.req_we = 1'b0; m0.req_funct3 = F3_BYTE;
    m0.req_addr = 32'd0; m0.req_wdata = 32'd0; m0.mem_rdata = 32'd0;
    drive(1'b1, 1'b1, F3_WORD, 32'h123, 32'hCAFE_BABE);
    rst_n = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({m.stall, m.fault, m.resp_valid, m.mem_we} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: stall/fault/resp_valid/mem_we=%b expected 0000", {m.stall, m.fault, m.resp_valid, m.mem_we});
    end
    checks++;
    if (m.mem_addr !== 32'd0 || m.mem_wdata !== 32'd0 || m.mem_funct3 !== 3'd0) begin
      errors++; $display("FAIL reset_mem_bus: addr=%h wdata=%h f3=%h expected all 0", m.mem_addr, m.mem_wdata, m.mem_funct3);
    end
    checks++;
    if (m.resp_rdata !== 32'd0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 00000000", m.resp_rdata);
    end
    checks++;
    if (dut.state_reg !== LSU_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected LSU_IDLE", dut.state_reg);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_aligned();
    poke4(10'h100, 32'h4433_2211);
    poke4(10'h104, 32'h8877_6655);
    @(negedge clk);
    drive(1'b1, 1'b0, F3_WORD, 32'h100, 32'd0); #1;
    checks++;
    if (m.stall !== 1'b0 || m.resp_valid !== 1'b1 || m.resp_rdata !== 32'h4433_2211 || m.mem_we !== 1'b0) begin
      errors++; $display("FAIL aligned_lw: stall=%b valid=%b rdata=%h we=%b expected 0 1 44332211 0", m.stall, m.resp_valid, m.resp_rdata, m.mem_we);
    end
    drive(1'b1, 1'b1, F3_BYTE, 32'h10A, 32'h0000_0077); #1;
    checks++;
    if (m.mem_we !== 1'b1 || m.resp_valid !== 1'b0 || m.stall !== 1'b0) begin
      errors++; $display("FAIL aligned_sb: we=%b valid=%b stall=%b expected 1 0 0", m.mem_we, m.resp_valid, m.stall);
    end
    @(negedge clk);
    idle(); #1;
    checks++;
    if (tmem[10'h10A] !== 8'h77) begin
      errors++; $display("FAIL aligned_sb_mem: got %h expected 77", tmem[10'h10A]);
    end
  endtask

  task automatic test_split_load();
    @(negedge clk);
    drive(1'b1, 1'b0, F3_WORD, 32'h101, 32'd0); #1;
    checks++;
    if (m.stall !== 1'b1 || m.mem_we !== 1'b0 || m.resp_valid !== 1'b0) begin
      errors++; $display("FAIL split_ld_accept: stall=%b we=%b valid=%b expected 1 0 0", m.stall, m.mem_we, m.resp_valid);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checks++;
      if ({m.stall, m.mem_we, m.mem_funct3, m.mem_addr} !== {1'b1, 1'b0, F3_BU, 32'h101 + 32'(k)}) begin
        errors++; $display("FAIL split_ld_beat%0d: stall=%b we=%b f3=%h addr=%h expected 1 0 4 %h", k, m.stall, m.mem_we, m.mem_funct3, m.mem_addr, 32'h101 + 32'(k));
      end
    end
    @(negedge clk); #1;
    checks++;
    if (m.stall !== 1'b0 || m.resp_valid !== 1'b1 || m.resp_rdata !== 32'h5544_3322) begin
      errors++; $display("FAIL split_ld_done: stall=%b valid=%b rdata=%h expected 0 1 55443322", m.stall, m.resp_valid, m.resp_rdata);
    end
    drive(1'b1, 1'b0, F3_WORD, 32'h104, 32'd0);
    @(negedge clk); #1;
    checks++;
    if (m.stall !== 1'b0 || m.resp_valid !== 1'b1 || m.resp_rdata !== 32'h8877_6655) begin
      errors++; $display("FAIL back_to_back: stall=%b valid=%b rdata=%h expected 0 1 88776655", m.stall, m.resp_valid, m.resp_rdata);
    end
    idle();
  endtask

  task automatic test_split_store();
    @(negedge clk);
    drive(1'b1, 1'b1, F3_HALF, 32'h103, 32'h0000_BEEF); #1;
    checks++;
    if (m.stall !== 1'b1 || m.mem_we !== 1'b0) begin
      errors++; $display("FAIL split_st_accept: stall=%b we=%b expected 1 0", m.stall, m.mem_we);
    end
    @(negedge clk); #1;
    checks++;
    if ({m.mem_we, m.mem_funct3, m.mem_addr, m.mem_wdata} !== {1'b1, F3_BYTE, 32'h103, 32'h0000_00EF}) begin
      errors++; $display("FAIL split_st_beat0: we=%b f3=%h addr=%h wdata=%h expected 1 0 103 000000ef", m.mem_we, m.mem_funct3, m.mem_addr, m.mem_wdata);
    end
    @(negedge clk); #1;
    checks++;
    if ({m.mem_we, m.mem_funct3, m.mem_addr, m.mem_wdata} !== {1'b1, F3_BYTE, 32'h104, 32'h0000_00BE}) begin
      errors++; $display("FAIL split_st_beat1: we=%b f3=%h addr=%h wdata=%h expected 1 0 104 000000be", m.mem_we, m.mem_funct3, m.mem_addr, m.mem_wdata);
    end
    @(negedge clk); #1;
    checks++;
    if (m.stall !== 1'b0 || m.mem_we !== 1'b0 || m.resp_valid !== 1'b0) begin
      errors++; $display("FAIL split_st_done: stall=%b we=%b valid=%b expected 0 0 0", m.stall, m.mem_we, m.resp_valid);
    end
    drive(1'b1, 1'b0, F3_WORD, 32'h100, 32'd0);
    @(negedge clk); #1;
    checks++;
    if (m.resp_rdata !== 32'hEF33_2211) begin
      errors++; $display("FAIL split_st_word0: got %h expected ef332211", m.resp_rdata);
    end
    drive(1'b1, 1'b0, F3_WORD, 32'h104, 32'd0); #1;
    checks++;
    if (m.resp_rdata !== 32'h8877_66BE) begin
      errors++; $display("FAIL split_st_word1: got %h expected 887766be", m.resp_rdata);
    end
    idle();
  endtask

  task automatic test_half_extend();
    logic [2:0]  f3;
    logic [31:0] exp;
    poke4(10'h103, 32'h0000_8544);
    for (int i = 0; i < 2; i++) begin
      f3  = (i == 0) ? F3_HALF : F3_HU;
      exp = (i == 0) ? 32'hFFFF_8544 : 32'h0000_8544;
      @(negedge clk);
      drive(1'b1, 1'b0, f3, 32'h103, 32'd0);
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (m.stall !== 1'b0 || m.resp_valid !== 1'b1 || m.resp_rdata !== exp) begin
        errors++; $display("FAIL half_extend_f3_%0d: stall=%b valid=%b rdata=%h expected 0 1 %h", f3, m.stall, m.resp_valid, m.resp_rdata, exp);
      end
      idle();
    end
  endtask

  task automatic test_fault();
    @(negedge clk);
    drive(1'b1, 1'b1, F3_WORD, 32'h8000_0001, 32'h1234_5678); #1;
    checks++;
    if (m.fault !== 1'b1 || m.stall !== 1'b0 || m.mem_we !== 1'b0 || m.resp_valid !== 1'b0) begin
      errors++; $display("FAIL mmio_fault: fault=%b stall=%b we=%b valid=%b expected 1 0 0 0", m.fault, m.stall, m.mem_we, m.resp_valid);
    end
    @(negedge clk);
    idle(); #1;
    checks++;
    if (m.fault !== 1'b0 || dut.state_reg !== LSU_IDLE) begin
      errors++; $display("FAIL mmio_fault_pulse: fault=%b state=%0d expected 0 IDLE", m.fault, dut.state_reg);
    end
    m0.req_valid = 1'b1; m0.req_we = 1'b0; m0.req_funct3 = F3_WORD; m0.req_addr = 32'h101; #1;
    checks++;
    if (m0.fault !== 1'b1 || m0.mem_we !== 1'b0 || m0.stall !== 1'b0) begin
      errors++; $display("FAIL nomisalign_fault: fault=%b we=%b stall=%b expected 1 0 0", m0.fault, m0.mem_we, m0.stall);
    end
    m0.req_we = 1'b1; m0.req_addr = 32'h100; #1;
    checks++;
    if (m0.fault !== 1'b0 || m0.mem_we !== 1'b1) begin
      errors++; $display("FAIL nomisalign_aligned: fault=%b we=%b expected 0 1", m0.fault, m0.mem_we);
    end
    m0.req_valid = 1'b0; m0.req_we = 1'b0;
  endtask

  task automatic test_reset_mid_split();
    poke4(10'h201, 32'h1413_1211);
    @(negedge clk);
    drive(1'b1, 1'b1, F3_WORD, 32'h201, 32'hDDCC_BBAA); #1;
    checks++;
    if (m.stall !== 1'b1 || m.mem_we !== 1'b0) begin
      errors++; $display("FAIL rst_split_accept: stall=%b we=%b expected 1 0", m.stall, m.mem_we);
    end
    @(negedge clk); #1;
    checks++;
    if ({m.mem_we, m.mem_addr, m.mem_wdata} !== {1'b1, 32'h201, 32'h0000_00AA}) begin
      errors++; $display("FAIL rst_split_beat0: we=%b addr=%h wdata=%h expected 1 201 000000aa", m.mem_we, m.mem_addr, m.mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b0; #1;
    checks++;
    if (m.mem_we !== 1'b0 || dut.state_reg !== LSU_IDLE || m.stall !== 1'b0) begin
      errors++; $display("FAIL rst_split_abort: we=%b state=%0d stall=%b expected 0 IDLE 0", m.mem_we, dut.state_reg, m.stall);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({tmem[10'h201], tmem[10'h202], tmem[10'h203], tmem[10'h204]} !== 32'hAA12_1314) begin
      errors++; $display("FAIL rst_split_mem: bytes 201..204=%h %h %h %h expected aa 12 13 14", tmem[10'h201], tmem[10'h202], tmem[10'h203], tmem[10'h204]);
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_split_load();
    test_split_store();
    test_half_extend();
    test_fault();
    test_reset_mid_split();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
